// File: rtl/routing_unit_lbdr_2d_vc.sv
// Per-input-port LBDR route computation with per-VC held output port.
// Define ROUTING_LBDR_ADAPTIVE_EN for credit-based selection among candidates.
package routing_unit_lbdr_2d_vc_pkg;
    typedef enum logic [1:0] {
        DIRECTION_NORTH,
        DIRECTION_EAST,
        DIRECTION_WEST,
        DIRECTION_SOUTH
    } direction_e;

    localparam int LBDR_2D_PORT_DIRECTION_INDEX_NORTH = 0;
    localparam int LBDR_2D_PORT_DIRECTION_INDEX_EAST  = 1;
    localparam int LBDR_2D_PORT_DIRECTION_INDEX_WEST  = 2;
    localparam int LBDR_2D_PORT_DIRECTION_INDEX_SOUTH = 3;
    localparam int LBDR_2D_PORT_DIRECTION_INDEX_LOCAL = 4;

    localparam int LBDR_BIT_RNE = 0;
    localparam int LBDR_BIT_RNW = 1;
    localparam int LBDR_BIT_REN = 2;
    localparam int LBDR_BIT_RES = 3;
    localparam int LBDR_BIT_RWN = 4;
    localparam int LBDR_BIT_RWS = 5;
    localparam int LBDR_BIT_RSE = 6;
    localparam int LBDR_BIT_RSW = 7;
    localparam int LBDR_BIT_CN  = 8;
    localparam int LBDR_BIT_CE  = 9;
    localparam int LBDR_BIT_CW  = 10;
    localparam int LBDR_BIT_CS  = 11;
endpackage

module routing_unit_lbdr_2d_vc
    import routing_unit_lbdr_2d_vc_pkg::*;
#(
    parameter int         DimensionXWidth         = 4,
    parameter int         DimensionYWidth         = 4,
    parameter direction_e NodeIdIncreaseXAxis     = DIRECTION_EAST,
    parameter direction_e NodeIdIncreaseYAxis     = DIRECTION_NORTH,
    parameter int         NumberOfLBDRBits        = 12,
    parameter logic [NumberOfLBDRBits-1:0] LbdrResetBits = 12'hFFF,
    parameter int         NumberOfPorts           = 5,
    parameter int         NumberOfVirtualChannels = 2,
    parameter int         CreditWidth             = 4,
    localparam int        VcIdxWidth =
        (NumberOfVirtualChannels > 1) ? $clog2(NumberOfVirtualChannels) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [DimensionXWidth-1:0]                 x_cur_i,
    input  logic [DimensionYWidth-1:0]                 y_cur_i,
    input  logic                                       cfg_we_i,
    input  logic [NumberOfLBDRBits-1:0]                cfg_lbdr_bits_i,
    output logic [NumberOfLBDRBits-1:0]                cfg_lbdr_bits_o,
    input  logic                                       hdr_valid_i,
    output logic                                       hdr_ready_o,
    input  logic [VcIdxWidth-1:0]                      hdr_vc_i,
    input  logic [DimensionXWidth-1:0]                 x_dst_i,
    input  logic [DimensionYWidth-1:0]                 y_dst_i,
    input  logic [NumberOfPorts*CreditWidth-1:0]       port_credits_i,
    input  logic [NumberOfVirtualChannels-1:0]         release_i,
    output logic [NumberOfVirtualChannels-1:0]         route_valid_o,
    output logic [NumberOfVirtualChannels*NumberOfPorts-1:0] route_port_o,
    output logic                                       err_unroutable_o
);

    typedef enum logic [1:0] {
        VC_IDLE,
        VC_COMPUTE,
        VC_ROUTED,
        VC_DROP
    } vc_state_e;

    vc_state_e state_q [NumberOfVirtualChannels];
    vc_state_e state_d [NumberOfVirtualChannels];

    logic [NumberOfLBDRBits-1:0] lbdr_q;
    logic [NumberOfPorts-1:0]    port_q [NumberOfVirtualChannels];
    logic                        s1_valid_q;
    logic [VcIdxWidth-1:0]       s1_vc_q;
    logic                        s1_n_q, s1_e_q, s1_w_q, s1_s_q;
    logic                        err_q;

    logic                        accept;
    logic                        vc_ok;
    logic                        x_gt, x_lt, y_gt, y_lt;
    logic                        q_n, q_e, q_w, q_s;
    logic [NumberOfPorts-1:0]    cand;
    logic [NumberOfPorts-1:0]    sel;
    logic                        found;

    assign vc_ok = int'(hdr_vc_i) < NumberOfVirtualChannels;
    assign hdr_ready_o = !rst_i && !s1_valid_q && vc_ok
                         && (state_q[hdr_vc_i] == VC_IDLE);
    assign accept = hdr_valid_i && hdr_ready_o;

    // Stage 1: raw quadrant, oriented by the node-id growth directions
    assign x_gt = x_dst_i > x_cur_i;
    assign x_lt = x_dst_i < x_cur_i;
    assign y_gt = y_dst_i > y_cur_i;
    assign y_lt = y_dst_i < y_cur_i;
    assign q_e  = (NodeIdIncreaseXAxis == DIRECTION_EAST) ? x_gt : x_lt;
    assign q_w  = (NodeIdIncreaseXAxis == DIRECTION_EAST) ? x_lt : x_gt;
    assign q_n  = (NodeIdIncreaseYAxis == DIRECTION_NORTH) ? y_gt : y_lt;
    assign q_s  = (NodeIdIncreaseYAxis == DIRECTION_NORTH) ? y_lt : y_gt;

    // Stage 2: LBDR candidate equations against the current register
    always_comb begin
        cand = '0;
        cand[LBDR_2D_PORT_DIRECTION_INDEX_NORTH] =
            ((s1_n_q && !s1_e_q && !s1_w_q)
             || (s1_n_q && s1_e_q && lbdr_q[LBDR_BIT_RNE])
             || (s1_n_q && s1_w_q && lbdr_q[LBDR_BIT_RNW]))
            && lbdr_q[LBDR_BIT_CN];
        cand[LBDR_2D_PORT_DIRECTION_INDEX_EAST] =
            ((s1_e_q && !s1_n_q && !s1_s_q)
             || (s1_e_q && s1_n_q && lbdr_q[LBDR_BIT_REN])
             || (s1_e_q && s1_s_q && lbdr_q[LBDR_BIT_RES]))
            && lbdr_q[LBDR_BIT_CE];
        cand[LBDR_2D_PORT_DIRECTION_INDEX_WEST] =
            ((s1_w_q && !s1_n_q && !s1_s_q)
             || (s1_w_q && s1_n_q && lbdr_q[LBDR_BIT_RWN])
             || (s1_w_q && s1_s_q && lbdr_q[LBDR_BIT_RWS]))
            && lbdr_q[LBDR_BIT_CW];
        cand[LBDR_2D_PORT_DIRECTION_INDEX_SOUTH] =
            ((s1_s_q && !s1_e_q && !s1_w_q)
             || (s1_s_q && s1_e_q && lbdr_q[LBDR_BIT_RSE])
             || (s1_s_q && s1_w_q && lbdr_q[LBDR_BIT_RSW]))
            && lbdr_q[LBDR_BIT_CS];
        cand[LBDR_2D_PORT_DIRECTION_INDEX_LOCAL] =
            !s1_n_q && !s1_e_q && !s1_w_q && !s1_s_q;
    end

`ifdef ROUTING_LBDR_ADAPTIVE_EN
    logic [CreditWidth-1:0] best;

    // Strict greater-than keeps N>E>W>S on equal credits
    always_comb begin
        sel   = '0;
        found = 1'b0;
        best  = '0;
        for (int p = 0; p < LBDR_2D_PORT_DIRECTION_INDEX_LOCAL; p++) begin
            if (cand[p] && (!found
                || port_credits_i[p*CreditWidth +: CreditWidth] > best)) begin
                sel    = '0;
                sel[p] = 1'b1;
                found  = 1'b1;
                best   = port_credits_i[p*CreditWidth +: CreditWidth];
            end
        end
        if (!found && cand[LBDR_2D_PORT_DIRECTION_INDEX_LOCAL]) begin
            sel[LBDR_2D_PORT_DIRECTION_INDEX_LOCAL] = 1'b1;
        end
    end
`else
    logic unused_credits;
    assign unused_credits = ^port_credits_i;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int p = 0; p < NumberOfPorts; p++) begin
            if (cand[p] && !found) begin
                sel[p] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        for (int v = 0; v < NumberOfVirtualChannels; v++) begin
            state_d[v] = state_q[v];
            unique case (state_q[v])
                VC_IDLE: begin
                    if (accept && hdr_vc_i == VcIdxWidth'(v)) begin
                        state_d[v] = VC_COMPUTE;
                    end
                end
                VC_COMPUTE: begin
                    if (s1_valid_q && s1_vc_q == VcIdxWidth'(v)) begin
                        state_d[v] = (|sel) ? VC_ROUTED : VC_DROP;
                    end
                end
                VC_ROUTED, VC_DROP: begin
                    if (release_i[v]) begin
                        state_d[v] = VC_IDLE;
                    end
                end
                default: state_d[v] = VC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int v = 0; v < NumberOfVirtualChannels; v++) begin
            if (rst_i) begin
                state_q[v] <= VC_IDLE;
            end else begin
                state_q[v] <= state_d[v];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lbdr_q     <= LbdrResetBits;
            s1_valid_q <= 1'b0;
            s1_vc_q    <= '0;
            s1_n_q     <= 1'b0;
            s1_e_q     <= 1'b0;
            s1_w_q     <= 1'b0;
            s1_s_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int v = 0; v < NumberOfVirtualChannels; v++) begin
                port_q[v] <= '0;
            end
        end else begin
            if (cfg_we_i) begin
                lbdr_q <= cfg_lbdr_bits_i;
            end
            s1_valid_q <= accept;
            if (accept) begin
                s1_vc_q <= hdr_vc_i;
                s1_n_q  <= q_n;
                s1_e_q  <= q_e;
                s1_w_q  <= q_w;
                s1_s_q  <= q_s;
            end
            err_q <= s1_valid_q && !(|sel);
            for (int v = 0; v < NumberOfVirtualChannels; v++) begin
                if (s1_valid_q && s1_vc_q == VcIdxWidth'(v)) begin
                    port_q[v] <= sel;
                end else if (release_i[v] && (state_q[v] == VC_ROUTED
                             || state_q[v] == VC_DROP)) begin
                    port_q[v] <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NumberOfVirtualChannels; v++) begin
            route_valid_o[v] = state_q[v] == VC_ROUTED;
            route_port_o[v*NumberOfPorts +: NumberOfPorts] = port_q[v];
        end
    end

    assign cfg_lbdr_bits_o  = lbdr_q;
    assign err_unroutable_o = err_q;

endmodule

// File: tb/tb_routing_unit_lbdr_2d_vc.sv
// Scoreboard bench for routing_unit_lbdr_2d_vc at router (1,1).
// Honours ROUTING_LBDR_ADAPTIVE_EN for the credit-selected cases.
module tb_routing_unit_lbdr_2d_vc;
    import routing_unit_lbdr_2d_vc_pkg::*;

    localparam logic [4:0] P_N = 5'b00001;
    localparam logic [4:0] P_E = 5'b00010;
    localparam logic [4:0] P_W = 5'b00100;
    localparam logic [4:0] P_S = 5'b01000;
    localparam logic [4:0] P_L = 5'b10000;
`ifdef ROUTING_LBDR_ADAPTIVE_EN
    localparam logic [4:0] P_NE = P_E;
`else
    localparam logic [4:0] P_NE = P_N;
`endif
    localparam logic [11:0] ALL = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  x_cur_i, y_cur_i;
    logic        cfg_we_i;
    logic [11:0] cfg_lbdr_bits_i, cfg_lbdr_bits_o;
    logic        hdr_valid_i, hdr_ready_o;
    logic [0:0]  hdr_vc_i;
    logic [3:0]  x_dst_i, y_dst_i;
    logic [19:0] port_credits_i;
    logic [1:0]  release_i, route_valid_o;
    logic [9:0]  route_port_o;
    logic        err_unroutable_o;

    routing_unit_lbdr_2d_vc dut (
        .clk_i(clk), .rst_i(rst_i),
        .x_cur_i(x_cur_i), .y_cur_i(y_cur_i),
        .cfg_we_i(cfg_we_i), .cfg_lbdr_bits_i(cfg_lbdr_bits_i),
        .cfg_lbdr_bits_o(cfg_lbdr_bits_o),
        .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
        .hdr_vc_i(hdr_vc_i), .x_dst_i(x_dst_i), .y_dst_i(y_dst_i),
        .port_credits_i(port_credits_i), .release_i(release_i),
        .route_valid_o(route_valid_o), .route_port_o(route_port_o),
        .err_unroutable_o(err_unroutable_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         vc;
        logic [4:0] port;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic [1:0] prev_rv = '0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: new route or error pulse pops one entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            prev_rv = '0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (route_valid_o[v] && !prev_rv[v]) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_route", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("route_vc", v, e.vc);
                        check("route_err", 0, e.err);
                        check("route_port", route_port_o[v*5 +: 5], e.port);
                        check("route_due", edge_cnt, e.due);
                    end
                end
            end
            if (err_unroutable_o) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_err", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("drop_err", 1, e.err);
                    check("drop_rv", route_valid_o[e.vc], 0);
                    check("drop_port", route_port_o[e.vc*5 +: 5], 0);
                    check("drop_due", edge_cnt, e.due);
                end
            end
            prev_rv = route_valid_o;
        end
    end

    task automatic send(input int vc, input int xd, input int yd,
                        input logic [4:0] port, input logic err,
                        input int cfg_at, input logic [11:0] cfg_val,
                        output int waits);
        exp_t e;
        waits = 0;
        @(negedge clk);
        release_i = '0;
        hdr_vc_i  = 1'(vc);
        x_dst_i   = 4'(xd);
        y_dst_i   = 4'(yd);
        #1;
        while (!hdr_ready_o && waits < 20) begin
            @(negedge clk);
            waits++;
            #1;
        end
        check("send_ready", hdr_ready_o, 1);
        hdr_valid_i = 1'b1;
        if (cfg_at == 1) begin
            cfg_we_i = 1'b1;
            cfg_lbdr_bits_i = cfg_val;
        end
        e.vc = vc; e.port = port; e.err = err; e.due = edge_cnt + 2;
        sb.push_back(e);
        @(negedge clk);
        hdr_valid_i = 1'b0;
        cfg_we_i = (cfg_at == 2);
        cfg_lbdr_bits_i = cfg_val;
        if (cfg_at == 2) begin
            @(negedge clk);
            cfg_we_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic cfg_write(input logic [11:0] val);
        @(negedge clk);
        cfg_we_i = 1'b1;
        cfg_lbdr_bits_i = val;
        @(negedge clk);
        cfg_we_i = 1'b0;
        #1;
        check("cfg_readback", cfg_lbdr_bits_o, val);
    endtask

    task automatic release_vc(input int vc);
        @(negedge clk);
        release_i = '0;
        release_i[vc] = 1'b1;
        @(negedge clk);
        release_i = '0;
        hdr_vc_i = 1'(vc);
        #1;
        check("rel_rv", route_valid_o[vc], 0);
        check("rel_port", route_port_o[vc*5 +: 5], 0);
        check("rel_ready", hdr_ready_o, 1);
    endtask

    initial begin
        int w;
        logic [9:0] held;
        rst_i = 1'b1;
        x_cur_i = 4'd1; y_cur_i = 4'd1;
        cfg_we_i = 1'b0; cfg_lbdr_bits_i = '0;
        hdr_valid_i = 1'b0; hdr_vc_i = '0;
        x_dst_i = '0; y_dst_i = '0;
        port_credits_i = 20'h00072;
        release_i = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", hdr_ready_o, 0);
        check("rst_rv", route_valid_o, 0);
        check("rst_port", route_port_o, 0);
        check("rst_err", err_unroutable_o, 0);
        check("rst_lbdr", cfg_lbdr_bits_o, ALL);
        rst_i = 1'b0;

        send(0, 1, 1, P_L, 0, 0, ALL, w);
        drain();
        release_vc(0);
        send(0, 3, 3, P_NE, 0, 0, ALL, w);
        drain();
        release_vc(0);

        cfg_write(ALL & ~(12'(1) << LBDR_BIT_CE));
        send(0, 3, 1, 5'b0, 1, 0, ALL, w);
        drain();
        hdr_vc_i = 1'b0;
        #1;
        check("drop_ready", hdr_ready_o, 0);
        repeat (3) @(negedge clk);
        check("drop_ready_hold", hdr_ready_o, 0);
        check("drop_rv_hold", route_valid_o[0], 0);
        release_vc(0);
        cfg_write(ALL);

        send(0, 1, 3, P_N, 0, 0, ALL, w);
        drain();
        @(negedge clk);
        hdr_vc_i = 1'b0; hdr_valid_i = 1'b1;
        #1;
        check("busy_ready", hdr_ready_o, 0);
        send(1, 3, 1, P_E, 0, 0, ALL, w);
        check("vc1_wait", w, 0);
        drain();
        @(negedge clk);
        hdr_vc_i = 1'b0; x_dst_i = 4'd0; y_dst_i = 4'd1;
        hdr_valid_i = 1'b1; release_i = 2'b01;
        #1;
        check("rel_cycle_ready", hdr_ready_o, 0);
        send(0, 0, 1, P_W, 0, 0, ALL, w);
        check("reaccept_wait", w, 0);
        drain();
        check("both_rv", route_valid_o, 2'b11);
        check("both_port", route_port_o, {P_E, P_W});
        held = route_port_o;
        cfg_write(12'h000);
        check("held_port", route_port_o, held);
        cfg_write(ALL);
        release_vc(0);
        release_vc(1);

        send(0, 3, 3, P_E, 0, 1, ALL & ~(12'(1) << LBDR_BIT_RNE), w);
        drain();
        send(1, 3, 3, P_E, 0, 2, ALL, w);
        drain();
        check("cfg_after_s2", cfg_lbdr_bits_o, ALL);
        release_vc(0);
        release_vc(1);

        send(0, 0, 3, P_N, 0, 0, ALL, w);
        send(1, 0, 0, P_W, 0, 0, ALL, w);
        drain();
        release_vc(0);
        release_vc(1);
        send(0, 3, 0, P_E, 0, 0, ALL, w);
        send(1, 1, 0, P_S, 0, 0, ALL, w);
        drain();
        release_vc(0);
        release_vc(1);

        cfg_write(ALL & ~(12'(1) << LBDR_BIT_CW));
        send(1, 3, 1, P_E, 0, 0, ALL, w);
        drain();
        send(0, 3, 3, P_NE, 0, 0, ALL, w);
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_rv", route_valid_o, 0);
        check("mid_rst_port", route_port_o, 0);
        check("mid_rst_err", err_unroutable_o, 0);
        check("mid_rst_lbdr", cfg_lbdr_bits_o, ALL);
        hdr_vc_i = 1'b1;
        #1;
        check("mid_rst_ready", hdr_ready_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_err", err_unroutable_o, 0);
        check("post_rst_rv", route_valid_o, 0);
        send(1, 1, 1, P_L, 0, 0, ALL, w);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
